// File: rtl/sync_block_pkg.sv
// Shared types for the scenario sequencer: scenario codes, FSM state codes, helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   DEF_CNT_W      default width of duration inputs and the elapsed-cycle counter
//   scenario_e     scenario code as selected by the upstream multiplexer
//   state_e        FSM state, encoded with the 8-bit codes reported upstream
//   is_phase       scenario includes a phase-alignment step
//   is_experiment  scenario fires the detonation line
//   is_counting    state is timed by a programmed duration
package sync_block_pkg;

   localparam int DEF_CNT_W = 32;

   typedef enum logic [1:0] {
      EXPERIMENT        = 2'd0,
      EXPERIMENT_PHASE  = 2'd1,
      CALIBRATION       = 2'd2,
      CALIBRATION_PHASE = 2'd3
   } scenario_e;

   typedef enum logic [7:0] {
      ST_IDLE        = 8'h00,
      ST_WAIT_FG     = 8'h01,
      ST_FG_DELAY    = 8'h02,
      ST_WAIT_READY  = 8'h03,
      ST_WAIT_PHASE  = 8'h04,
      ST_PHASE_SHIFT = 8'h05,
      ST_DETONATE    = 8'h06,
      ST_TRIGGER     = 8'h07,
      ST_DONE        = 8'h08,
      ST_ERROR       = 8'hFF
   } state_e;

   // Odd codes are the phase variants.
   function automatic logic is_phase(input scenario_e s);
      return s[0];
   endfunction

   // Codes 0 and 1 are the experiment variants.
   function automatic logic is_experiment(input scenario_e s);
      return ~s[1];
   endfunction

   function automatic logic is_counting(input state_e s);
      return (s == ST_FG_DELAY) || (s == ST_PHASE_SHIFT) ||
             (s == ST_DETONATE) || (s == ST_TRIGGER);
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes one asynchronous input and flags its rising and falling edges.
// Latency: sync valid SYNC_DEPTH cycles after the input settles; rise/fall are combinational on sync.
// Backpressure: none; every edge produces a single-cycle pulse.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (chain cleared to 0)
//   din         asynchronous input
//   sync        synchronized level
//   rise, fall  one-cycle pulses on synchronized 0->1 / 1->0 transitions
module sync_edge_detect #(
   parameter int SYNC_DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic [SYNC_DEPTH-1:0] chain;
   logic                  prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
         prev  <= 1'b0;
      end else begin
         chain <= {chain[SYNC_DEPTH-2:0], din};
         prev  <= chain[SYNC_DEPTH-1];
      end
   end

   assign sync = chain[SYNC_DEPTH-1];
   assign rise = sync & ~prev;
   assign fall = ~sync & prev;

endmodule

// File: rtl/scenario_sequencer.sv
// Runs one synchronization sequence (fg open, delay, ready, phase, detonate, trigger).
// Latency: async input edge to state change is SYNC_DEPTH+1 cycles; outputs follow state.
// Backpressure: none; abort returns to IDLE on the next clock from any state.
//
// Ports:
//   clock_reg_input, reset_reg_input      clock, asynchronous active-low reset
//   abort_reg_input                       synchronous abort to IDLE
//   control_reg_input                     scenario code, taken only when a start is accepted
//   start/fg/phase/wire/detector_ready    asynchronous inputs, synchronized here
//   *_len / *_delay / *_timeout / *_shift programmed durations in cycles, sampled on state entry
//   detonation_signal/trigger/done/error  registered Moore outputs
//   scenario_state_reg_output             8-bit state code
//   counter_reg_output                    elapsed cycles in a timed state, else 0
module scenario_sequencer
   import sync_block_pkg::*;
#(
   parameter int CNT_W      = DEF_CNT_W,
   parameter int SYNC_DEPTH = 2
) (
   input  logic             clock_reg_input,
   input  logic             reset_reg_input,
   input  logic             abort_reg_input,
   input  logic [2:0]       control_reg_input,
   input  logic             start_reg_input,
   input  logic             fg_reg_input,
   input  logic             phase_reg_input,
   input  logic             wire_reg_input,
   input  logic             detector_ready_reg_input,
   input  logic [CNT_W-1:0] fg_open_delay_reg_input,
   input  logic [CNT_W-1:0] detectr_ready_timeout_reg_input,
   input  logic [CNT_W-1:0] phase_shift_reg_input,
   input  logic [CNT_W-1:0] detonate_len_reg_input,
   input  logic [CNT_W-1:0] trigger_len_reg_input,
   output logic             detonation_signal_reg_output,
   output logic             trigger_reg_output,
   output logic [7:0]       scenario_state_reg_output,
   output logic [CNT_W-1:0] counter_reg_output,
   output logic             done_reg_output,
   output logic             error_reg_output
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic start_sync, start_rise, start_fall;
   logic fg_sync, fg_rise, fg_fall;
   logic phase_sync, phase_rise, phase_fall;
   logic wire_sync, wire_rise, wire_fall;
   logic ready_sync, ready_rise, ready_fall;

   sync_edge_detect #(.SYNC_DEPTH(SYNC_DEPTH)) u_start (
      .clk(clock_reg_input), .rst_n(reset_reg_input), .din(start_reg_input),
      .sync(start_sync), .rise(start_rise), .fall(start_fall));
   sync_edge_detect #(.SYNC_DEPTH(SYNC_DEPTH)) u_fg (
      .clk(clock_reg_input), .rst_n(reset_reg_input), .din(fg_reg_input),
      .sync(fg_sync), .rise(fg_rise), .fall(fg_fall));
   sync_edge_detect #(.SYNC_DEPTH(SYNC_DEPTH)) u_phase (
      .clk(clock_reg_input), .rst_n(reset_reg_input), .din(phase_reg_input),
      .sync(phase_sync), .rise(phase_rise), .fall(phase_fall));
   sync_edge_detect #(.SYNC_DEPTH(SYNC_DEPTH)) u_wire (
      .clk(clock_reg_input), .rst_n(reset_reg_input), .din(wire_reg_input),
      .sync(wire_sync), .rise(wire_rise), .fall(wire_fall));
   sync_edge_detect #(.SYNC_DEPTH(SYNC_DEPTH)) u_ready (
      .clk(clock_reg_input), .rst_n(reset_reg_input), .din(detector_ready_reg_input),
      .sync(ready_sync), .rise(ready_rise), .fall(ready_fall));

   // Edge/level flavours this FSM has no use for.
   logic unused_edges;
   assign unused_edges = ^{start_fall, fg_sync, fg_fall, phase_sync, phase_fall,
                           wire_rise, wire_fall, ready_rise, ready_fall};

   state_e           state, nxt;
   scenario_e        scen;
   logic [CNT_W-1:0] cnt;   // cycles spent in the current state
   logic [CNT_W-1:0] dur;   // duration (or timeout) captured on state entry
   logic [CNT_W-1:0] dur_nxt;
   logic             last;

   // Entry targets with zero-length timed states folded away, so a skipped
   // state costs no cycles and produces no pulse.
   state_e trig_tgt, det_tgt, fire_tgt, ps_tgt, fg_tgt;

   assign last = (cnt == dur - ONE);

   always_comb begin
      trig_tgt = (trigger_len_reg_input == '0) ? ST_DONE : ST_TRIGGER;
      det_tgt  = (detonate_len_reg_input == '0) ? trig_tgt : ST_DETONATE;
      fire_tgt = is_experiment(scen) ? det_tgt : trig_tgt;
      ps_tgt   = (phase_shift_reg_input == '0) ? fire_tgt : ST_PHASE_SHIFT;
      fg_tgt   = (fg_open_delay_reg_input == '0) ? ST_WAIT_READY : ST_FG_DELAY;
   end

   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE: begin
            // Scenario is not latched yet in this cycle, so decode the raw code.
            if (start_rise && control_reg_input <= 3'd3) begin
               if (!control_reg_input[1] && !wire_sync) nxt = ST_ERROR;
               else                                     nxt = ST_WAIT_FG;
            end
         end
         ST_WAIT_FG:     if (fg_rise) nxt = fg_tgt;
         ST_FG_DELAY:    if (last) nxt = ST_WAIT_READY;
         ST_WAIT_READY: begin
            if (ready_sync)                nxt = is_phase(scen) ? ST_WAIT_PHASE : fire_tgt;
            else if (dur != '0 && last)    nxt = ST_ERROR;
         end
         ST_WAIT_PHASE:  if (phase_rise) nxt = ps_tgt;
         ST_PHASE_SHIFT: if (last) nxt = fire_tgt;
         // A broken wire ends the pulse early; the level is used so the exit
         // happens on the cycle after the first wire=0 sample.
         ST_DETONATE:    if (last || !wire_sync) nxt = trig_tgt;
         ST_TRIGGER:     if (last) nxt = ST_DONE;
         ST_DONE:        if (!start_sync) nxt = ST_IDLE;
         ST_ERROR:       nxt = ST_ERROR;
         default:        nxt = ST_IDLE;
      endcase
      if (abort_reg_input) nxt = ST_IDLE;
   end

   always_comb begin
      case (nxt)
         ST_FG_DELAY:    dur_nxt = fg_open_delay_reg_input;
         ST_WAIT_READY:  dur_nxt = detectr_ready_timeout_reg_input;
         ST_PHASE_SHIFT: dur_nxt = phase_shift_reg_input;
         ST_DETONATE:    dur_nxt = detonate_len_reg_input;
         ST_TRIGGER:     dur_nxt = trigger_len_reg_input;
         default:        dur_nxt = '0;
      endcase
   end

   always_ff @(posedge clock_reg_input or negedge reset_reg_input) begin
      if (!reset_reg_input) begin
         state                        <= ST_IDLE;
         scen                         <= EXPERIMENT;
         cnt                          <= '0;
         dur                          <= '0;
         detonation_signal_reg_output <= 1'b0;
         trigger_reg_output           <= 1'b0;
         done_reg_output              <= 1'b0;
         error_reg_output             <= 1'b0;
      end else begin
         state <= nxt;
         // Leaving IDLE means a start was accepted with a valid code.
         if (state == ST_IDLE && nxt != ST_IDLE)
            scen <= scenario_e'(control_reg_input[1:0]);
         if (nxt != state) begin
            cnt <= '0;
            dur <= dur_nxt;
         end else if (cnt != '1) begin
            cnt <= cnt + ONE;
         end
         detonation_signal_reg_output <= (nxt == ST_DETONATE);
         trigger_reg_output           <= (nxt == ST_TRIGGER);
         done_reg_output              <= (nxt == ST_DONE);
         error_reg_output             <= (nxt == ST_ERROR);
      end
   end

   assign scenario_state_reg_output = state;
   assign counter_reg_output        = is_counting(state) ? cnt : '0;

endmodule

// File: tb/tb_scenario_sequencer.sv
// Self-checking bench for scenario_sequencer: expected state segments (code, length)
// are queued as each run is launched and compared as the monitor sees them complete.
module tb_scenario_sequencer;

   localparam int CNT_W = 32;
   localparam int SD    = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             abort = 1'b0;
   logic [2:0]       control = 3'd0;
   logic             start = 1'b0, fg = 1'b0, phase = 1'b0, wire_i = 1'b1, ready = 1'b0;
   logic [CNT_W-1:0] fg_dly = '0, tmo = '0, ps = '0, det_len = '0, trg_len = '0;

   logic             det_o, trg_o, done_o, err_o;
   logic [7:0]       st_o;
   logic [CNT_W-1:0] cnt_o;

   int checks = 0;
   int errors = 0;
   int det_total = 0;
   int trg_total = 0;
   int d0, t0;

   typedef struct {
      logic [7:0] st;
      int         len;   // -1: length not checked
   } seg_t;
   seg_t exp_q[$];

   always #5 clk = ~clk;

   scenario_sequencer #(.CNT_W(CNT_W), .SYNC_DEPTH(SD)) dut (
      .clock_reg_input                 (clk),
      .reset_reg_input                 (rst_n),
      .abort_reg_input                 (abort),
      .control_reg_input               (control),
      .start_reg_input                 (start),
      .fg_reg_input                    (fg),
      .phase_reg_input                 (phase),
      .wire_reg_input                  (wire_i),
      .detector_ready_reg_input        (ready),
      .fg_open_delay_reg_input         (fg_dly),
      .detectr_ready_timeout_reg_input (tmo),
      .phase_shift_reg_input           (ps),
      .detonate_len_reg_input          (det_len),
      .trigger_len_reg_input           (trg_len),
      .detonation_signal_reg_output    (det_o),
      .trigger_reg_output              (trg_o),
      .scenario_state_reg_output       (st_o),
      .counter_reg_output              (cnt_o),
      .done_reg_output                 (done_o),
      .error_reg_output                (err_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic push_seg(input logic [7:0] s, input int len);
      seg_t e;
      e.st  = s;
      e.len = len;
      exp_q.push_back(e);
   endtask

   // Bounded wait; the final chk fails if the budget ran out first.
   task automatic wait_state(input string tag, input logic [7:0] s, input int budget);
      int n;
      n = 0;
      while (st_o !== s && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, st_o, s);
   endtask

   // Monitor: measures each state segment in cycles and checks it against the queue.
   initial begin : monitor
      logic [7:0] cur;
      int         len;
      seg_t       e;
      @(posedge rst_n);
      @(negedge clk);
      cur = st_o;
      len = 1;
      forever begin
         @(negedge clk);
         if (det_o) det_total++;
         if (trg_o) trg_total++;
         if (st_o !== cur) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else begin
               e.st  = 8'hEE;
               e.len = -1;
            end
            chk($sformatf("seg_state_%02h", cur), cur, e.st);
            if (e.len >= 0) chk($sformatf("seg_len_%02h", cur), len, e.len);
            cur = st_o;
            len = 1;
         end else begin
            len++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset state
      #1;
      chk("rst_state", st_o, 8'h00);
      chk("rst_det", det_o, 0);
      chk("rst_trg", trg_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_cnt", cnt_o, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // 1: EXPERIMENT, ready already high
      control = 3'd0; fg_dly = 10; det_len = 5; trg_len = 3; tmo = 0; ready = 1'b1; wire_i = 1'b1;
      repeat (5) @(negedge clk);
      d0 = det_total; t0 = trg_total;
      push_seg(8'h00, -1); push_seg(8'h01, -1); push_seg(8'h02, 10); push_seg(8'h03, 1);
      push_seg(8'h06, 5); push_seg(8'h07, 3); push_seg(8'h08, -1);
      start = 1'b1;
      wait_state("t1_wait_fg", 8'h01, 20);
      fg = 1'b1;
      wait_state("t1_fg_delay", 8'h02, 20);
      chk("t1_cnt0", cnt_o, 0);
      repeat (4) @(negedge clk);
      chk("t1_cnt4", cnt_o, 4);
      wait_state("t1_done", 8'h08, 60);
      chk("t1_done_o", done_o, 1);
      start = 1'b0; fg = 1'b0;
      wait_state("t1_idle", 8'h00, 20);
      repeat (2) @(negedge clk);
      chk("t1_det_width", det_total - d0, 5);
      chk("t1_trg_width", trg_total - t0, 3);
      chk("t1_queue", exp_q.size(), 0);

      // 2: CALIBRATION_PHASE, phase edge 20 cycles into WAIT_PHASE
      control = 3'd3; fg_dly = 4; ps = 7; trg_len = 4; det_len = 5;
      repeat (3) @(negedge clk);
      d0 = det_total; t0 = trg_total;
      push_seg(8'h00, -1); push_seg(8'h01, -1); push_seg(8'h02, 4); push_seg(8'h03, 1);
      push_seg(8'h04, 20 + SD + 1); push_seg(8'h05, 7); push_seg(8'h07, 4); push_seg(8'h08, -1);
      start = 1'b1;
      wait_state("t2_wait_fg", 8'h01, 20);
      fg = 1'b1;
      wait_state("t2_wait_phase", 8'h04, 30);
      repeat (20) @(negedge clk);
      phase = 1'b1;
      wait_state("t2_done", 8'h08, 60);
      start = 1'b0; fg = 1'b0; phase = 1'b0;
      wait_state("t2_idle", 8'h00, 20);
      repeat (2) @(negedge clk);
      chk("t2_no_detonation", det_total - d0, 0);
      chk("t2_trg_width", trg_total - t0, 4);
      chk("t2_queue", exp_q.size(), 0);

      // 3: ready never arrives, timeout 100
      control = 3'd0; fg_dly = 3; tmo = 100; ready = 1'b0;
      repeat (4) @(negedge clk);
      push_seg(8'h00, -1); push_seg(8'h01, -1); push_seg(8'h02, 3); push_seg(8'h03, 100);
      push_seg(8'hFF, -1);
      start = 1'b1;
      wait_state("t3_wait_fg", 8'h01, 20);
      fg = 1'b1;
      wait_state("t3_error", 8'hFF, 150);
      chk("t3_err_o", err_o, 1);
      start = 1'b0; fg = 1'b0;
      repeat (20) @(negedge clk);
      chk("t3_err_held", err_o, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("t3_abort_state", st_o, 8'h00);
      chk("t3_abort_err", err_o, 0);
      repeat (2) @(negedge clk);
      chk("t3_queue", exp_q.size(), 0);

      // 4: long detonation cut short by the breakwire
      control = 3'd0; fg_dly = 1; tmo = 0; ready = 1'b1; det_len = 1000; trg_len = 2;
      repeat (4) @(negedge clk);
      d0 = det_total;
      push_seg(8'h00, -1); push_seg(8'h01, -1); push_seg(8'h02, 1); push_seg(8'h03, 1);
      push_seg(8'h06, 50 + SD + 1); push_seg(8'h07, 2); push_seg(8'h08, -1);
      start = 1'b1;
      wait_state("t4_wait_fg", 8'h01, 20);
      fg = 1'b1;
      wait_state("t4_detonate", 8'h06, 30);
      repeat (50) @(negedge clk);
      wire_i = 1'b0;
      wait_state("t4_done", 8'h08, 80);
      chk("t4_det_width", det_total - d0, 50 + SD + 1);
      start = 1'b0; fg = 1'b0; wire_i = 1'b1;
      wait_state("t4_idle", 8'h00, 20);
      repeat (2) @(negedge clk);
      chk("t4_queue", exp_q.size(), 0);

      // 5: zero fg delay and zero trigger length, start held high in DONE
      control = 3'd2; fg_dly = 0; trg_len = 0; det_len = 5;
      repeat (4) @(negedge clk);
      t0 = trg_total;
      push_seg(8'h00, -1); push_seg(8'h01, -1); push_seg(8'h03, 1); push_seg(8'h08, -1);
      start = 1'b1;
      wait_state("t5_wait_fg", 8'h01, 20);
      fg = 1'b1;
      wait_state("t5_done", 8'h08, 20);
      repeat (30) @(negedge clk);
      chk("t5_hold_done", st_o, 8'h08);
      chk("t5_done_o", done_o, 1);
      start = 1'b0; fg = 1'b0;
      wait_state("t5_idle", 8'h00, 20);
      repeat (2) @(negedge clk);
      chk("t5_no_trigger", trg_total - t0, 0);
      chk("t5_queue", exp_q.size(), 0);

      // 6: async reset mid-DETONATE, then an invalid scenario code
      control = 3'd0; fg_dly = 2; det_len = 1000; trg_len = 3;
      repeat (4) @(negedge clk);
      push_seg(8'h00, -1); push_seg(8'h01, -1); push_seg(8'h02, 2); push_seg(8'h03, 1);
      push_seg(8'h06, -1);
      start = 1'b1;
      wait_state("t6_wait_fg", 8'h01, 20);
      fg = 1'b1;
      wait_state("t6_detonate", 8'h06, 30);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_det", det_o, 0);
      chk("t6_rst_state", st_o, 8'h00);
      chk("t6_rst_cnt", cnt_o, 0);
      start = 1'b0; fg = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      control = 3'd5;
      start = 1'b1;
      repeat (10) @(negedge clk);
      chk("t6_bad_code_idle", st_o, 8'h00);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("t6_queue", exp_q.size(), 0);

      // 7: experiment start with breakwire already cut
      control = 3'd1; wire_i = 1'b0;
      repeat (4) @(negedge clk);
      push_seg(8'h00, -1); push_seg(8'hFF, -1);
      start = 1'b1;
      wait_state("t7_error", 8'hFF, 10);
      chk("t7_err_o", err_o, 1);
      start = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_state("t7_idle", 8'h00, 5);
      wire_i = 1'b1;
      repeat (2) @(negedge clk);
      chk("t7_queue", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
